// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains len words from a registered-read FIFO onto a valid/ready stream.
// Optional FIFO_RD_LAST_EN adds m_last, tagging the final word of each transfer.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  fifo_rden,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   input  logic                  fifo_empty,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready
`ifdef FIFO_RD_LAST_EN
   ,
   output logic                  m_last
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t                state;
   logic [LEN_WIDTH-1:0]  rem_rd;
   logic [LEN_WIDTH-1:0]  rem_out;
   logic                  inflight;
   logic [1:0]            skid_cnt;
   logic [DATA_WIDTH-1:0] skid_d0;
   logic [DATA_WIDTH-1:0] skid_d1;
   logic                  pop;
   logic                  wr;
   logic [2:0]            occ;

   assign pop = m_valid & m_ready;
   assign wr  = inflight;

   // Words held after this edge: skid entries plus the one still in flight.
   assign occ = {1'b0, skid_cnt}
              + {2'b00, inflight}
              - {2'b00, pop};

   assign fifo_rden = (state == RUN)
                    && !fifo_empty
                    && (rem_rd != '0)
                    && (occ < 3'd2);

   assign m_valid = (skid_cnt != 2'd0);
   assign m_data  = skid_d0;

   // Transfer sequencing with registered busy/done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rem_rd  <= '0;
         rem_out <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (len != '0) begin
                     state   <= RUN;
                     rem_rd  <= len;
                     rem_out <= len;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (fifo_rden) begin
                  rem_rd <= rem_rd - LEN_WIDTH'(1);
                  if (rem_rd == LEN_WIDTH'(1)) begin
                     state <= DRAIN;
                  end
               end
               if (pop) begin
                  rem_out <= rem_out - LEN_WIDTH'(1);
               end
            end
            DRAIN: begin
               if (pop) begin
                  rem_out <= rem_out - LEN_WIDTH'(1);
                  if (rem_out == LEN_WIDTH'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Two-entry skid: head feeds m_data, tail catches the in-flight word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         skid_cnt <= 2'd0;
         skid_d0  <= '0;
         skid_d1  <= '0;
      end else begin
         inflight <= fifo_rden;
         unique case ({wr, pop})
            2'b10: begin
               if (skid_cnt == 2'd0) begin
                  skid_d0 <= fifo_rdata;
               end else begin
                  skid_d1 <= fifo_rdata;
               end
               skid_cnt <= skid_cnt + 2'd1;
            end
            2'b01: begin
               skid_d0  <= skid_d1;
               skid_cnt <= skid_cnt - 2'd1;
            end
            2'b11: begin
               if (skid_cnt == 2'd1) begin
                  skid_d0 <= fifo_rdata;
               end else begin
                  skid_d0 <= skid_d1;
                  skid_d1 <= fifo_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef FIFO_RD_LAST_EN
   logic inflight_last;
   logic skid_l0;
   logic skid_l1;

   assign m_last = m_valid & skid_l0;

   // Last-word tags travel alongside the skid data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_last <= 1'b0;
         skid_l0       <= 1'b0;
         skid_l1       <= 1'b0;
      end else begin
         inflight_last <= fifo_rden
                        && (rem_rd == LEN_WIDTH'(1));
         unique case ({wr, pop})
            2'b10: begin
               if (skid_cnt == 2'd0) begin
                  skid_l0 <= inflight_last;
               end else begin
                  skid_l1 <= inflight_last;
               end
            end
            2'b01: begin
               skid_l0 <= skid_l1;
               skid_l1 <= 1'b0;
            end
            2'b11: begin
               if (skid_cnt == 2'd1) begin
                  skid_l0 <= inflight_last;
               end else begin
                  skid_l0 <= skid_l1;
                  skid_l1 <= inflight_last;
               end
            end
            default: begin
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scoreboard bench for fifo_stream_reader.
// Define FIFO_RD_LAST_EN to also check m_last.
module tb_fifo_stream_reader;
   localparam int DW = 8;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic          busy;
   logic          done;
   logic          fifo_rden;
   logic [DW-1:0] fifo_rdata = '0;
   logic          fifo_empty = 1'b1;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready = 1'b1;
`ifdef FIFO_RD_LAST_EN
   logic          m_last;
`endif

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] fq[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int uflow = 0;
   int pop_cnt = 0;
   int os_base = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_pop_cyc = 0;
   logic bp_en = 1'b0;
   logic pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1};

   fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .fifo_rden  (fifo_rden),
      .fifo_rdata (fifo_rdata),
      .fifo_empty (fifo_empty),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready)
`ifdef FIFO_RD_LAST_EN
      ,
      .m_last     (m_last)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Registered-read FIFO model.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rden) begin
         rd_cnt <= rd_cnt + 1;
         if (fq.size() == 0) begin
            uflow <= uflow + 1;
         end else begin
            fifo_rdata <= fq.pop_front();
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         fifo_empty = (fq.size() == 0);
      end
   end

   // Downstream ready driver.
   initial begin
      int idx;
      idx = 0;
      forever begin
         @(posedge clk);
         #1;
         if (bp_en) begin
            m_ready = pat[idx % 12];
            idx++;
         end else begin
            m_ready = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on every presented handshake.
   initial begin
      logic          stall;
      logic [DW-1:0] hold_d;
      exp_t          e;
      stall = 1'b0;
      hold_d = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk("hold_valid", int'(m_valid), 1);
               chk("hold_data", int'(m_data), int'(hold_d));
            end
            if (busy) begin
               chk("outstanding_le2",
                   int'((rd_cnt - pop_cnt - os_base) <= 2), 1);
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
`ifdef FIFO_RD_LAST_EN
            if (!m_valid) begin
               chk("m_last_idle", int'(m_last), 0);
            end
`endif
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_word: got %0h expected none",
                           m_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("m_data", int'(m_data), int'(e.d));
`ifdef FIFO_RD_LAST_EN
                  chk("m_last", int'(m_last), int'(e.l));
`endif
               end
               pop_cnt++;
               last_pop_cyc = cyc;
            end
            stall = m_valid && !m_ready;
            hold_d = m_data;
         end
      end
   end

   task automatic push_word(input logic [DW-1:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      fq.push_back(d);
      exp_q.push_back(e);
   endtask

   task automatic kick(input int l);
      @(posedge clk);
      #1;
      start = 1'b1;
      len = LW'(l);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input bit chk_lat);
      int n0;
      int k;
      n0 = done_cnt;
      k = 0;
      while (done_cnt == n0 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (done_cnt == n0) begin
         chk({name, "_timeout"}, 0, 1);
      end else begin
         chk({name, "_busy_after"}, int'(busy), 0);
         if (chk_lat) begin
            chk({name, "_done_lat"}, done_cyc, last_pop_cyc + 1);
         end
      end
   endtask

   initial begin
      int rd0;
      int p0;
      int k;

      // reset state
      #12;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rden", int'(fifo_rden), 0);
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_data", int'(m_data), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // basic transfer with latency checks
      for (int i = 0; i < 4; i++) begin
         push_word(DW'(8'h11 + i), i == 3);
      end
      rd0 = rd_cnt;
      kick(4);
      chk("basic_rden_t1", int'(fifo_rden), 1);
      chk("basic_busy", int'(busy), 1);
      chk("basic_valid_t1", int'(m_valid), 0);
      @(posedge clk);
      #1;
      chk("basic_valid_t2", int'(m_valid), 0);
      @(posedge clk);
      #1;
      chk("basic_valid_t3", int'(m_valid), 1);
      chk("basic_first", int'(m_data), 8'h11);
      wait_done("basic", 1'b1);
      chk("basic_reads", rd_cnt - rd0, 4);

      // back-pressure
      for (int i = 0; i < 6; i++) begin
         push_word(DW'(8'h21 + i), i == 5);
      end
      rd0 = rd_cnt;
      bp_en = 1'b1;
      kick(6);
      wait_done("bp", 1'b1);
      bp_en = 1'b0;
      chk("bp_reads", rd_cnt - rd0, 6);

      // empty stall
      rd0 = rd_cnt;
      kick(3);
      for (int i = 0; i < 5; i++) begin
         chk("stall_rden", int'(fifo_rden), 0);
         chk("stall_busy", int'(busy), 1);
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 3; i++) begin
         push_word(DW'(8'hA0 + i), i == 2);
      end
      wait_done("stall", 1'b1);
      chk("stall_reads", rd_cnt - rd0, 3);

      // zero length
      rd0 = rd_cnt;
      kick(0);
      chk("zero_done", int'(done), 1);
      chk("zero_busy", int'(busy), 1);
      chk("zero_rden", int'(fifo_rden), 0);
      @(posedge clk);
      #1;
      chk("zero_done_off", int'(done), 0);
      chk("zero_busy_off", int'(busy), 0);
      chk("zero_reads", rd_cnt - rd0, 0);

      // start while busy is ignored
      for (int i = 0; i < 3; i++) begin
         push_word(DW'(8'h31 + i), i == 2);
      end
      rd0 = rd_cnt;
      kick(3);
      start = 1'b1;
      len = LW'(7);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("ignore", 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("ignore_idle", int'(busy), 0);
      chk("ignore_reads", rd_cnt - rd0, 3);

      // reset mid-transfer
      for (int i = 0; i < 5; i++) begin
         push_word(DW'(8'h41 + i), i == 4);
      end
      p0 = pop_cnt;
      kick(5);
      k = 0;
      while (pop_cnt < p0 + 2 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("mid_two_popped", pop_cnt - p0, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", int'(m_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_rden", int'(fifo_rden), 0);
      fq.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      os_base = rd_cnt - pop_cnt;
      rst_n = 1'b1;
      push_word(8'h5A, 1'b0);
      push_word(8'h5B, 1'b1);
      rd0 = rd_cnt;
      kick(2);
      wait_done("post_rst", 1'b1);
      chk("post_rst_reads", rd_cnt - rd0, 2);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("no_underflow", uflow, 0);
      chk("done_pulses", done_cnt, 6);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
